// File: rtl/dec_bp_pkg.sv
// Shared definitions for the BP decode path: parser FSM states, the legal
// range of the per-code bit width, and the width derivation helper.
package dec_bp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PARSE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int BPV_BITS_MIN       = 1;
  localparam int BPV_BITS_MAX       = 7;
  localparam int FLS_OFFSET_DEFAULT = 32;

  // FLS mode spends one signalled bit on the offset, so codes are one bit
  // narrower. Anything outside the legal range collapses to a zero-width
  // code, which consumes nothing and reads back as 0.
  function automatic logic [2:0] calc_b(input logic [3:0] num_bits,
                                        input logic       is_fls);
    logic [3:0] w;
    w = is_fls ? (num_bits - 4'd1) : num_bits;
    if ((w < 4'(BPV_BITS_MIN)) || (w > 4'(BPV_BITS_MAX))) begin
      return 3'd0;
    end
    return w[2:0];
  endfunction

endpackage

// File: rtl/dec_bpv_parser_if.sv
// Request/result bundle between the BP suffix source, the BPV parser and
// the downstream entropy-group decoder.
interface dec_bpv_parser_if #(
  parameter int SUFFIX_W = 128,
  parameter int NUM_PART = 4,
  parameter int BPV_W    = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [SUFFIX_W-1:0]       suffix;
  logic [NUM_PART-1:0]       use2x2;
  logic [3:0]                bpv_num_bits;
  logic                      is_fls;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_PART*BPV_W-1:0] bpv_p0;
  logic [NUM_PART*BPV_W-1:0] bpv_p1;
  logic [7:0]                bpv_size;
  logic [SUFFIX_W-1:0]       suffix_rm;
  logic                      overrun;

  // Requester side: issues blocks and consumes results.
  modport master (
    output in_valid, suffix, use2x2, bpv_num_bits, is_fls, out_ready,
    input  in_ready, out_valid, bpv_p0, bpv_p1, bpv_size, suffix_rm, overrun
  );

  // Parser side.
  modport slave (
    input  in_valid, suffix, use2x2, bpv_num_bits, is_fls, out_ready,
    output in_ready, out_valid, bpv_p0, bpv_p1, bpv_size, suffix_rm, overrun
  );
endinterface

// File: rtl/dec_bpv_extract.sv
// Combinational code extractor: pulls one or two b-bit codes off the top of
// the working register and reports how far the register must shift.
module dec_bpv_extract
  import dec_bp_pkg::*;
#(
  parameter int SUFFIX_W = 128
) (
  input  logic [SUFFIX_W-1:0]     work_i,
  input  logic [2:0]              b_i,
  input  logic                    use2x2_i,
  output logic [BPV_BITS_MAX-1:0] c0_o,
  output logic [BPV_BITS_MAX-1:0] c1_o,
  output logic [4:0]              shamt_o
);

  logic [SUFFIX_W-1:0] after_c0;
  int                  rsh;

  // A right shift by SUFFIX_W-b leaves the top b bits; b=0 shifts the whole
  // word out, which yields the required all-zero code for free.
  always_comb begin
    rsh      = SUFFIX_W - int'(b_i);
    after_c0 = work_i << b_i;
    c0_o     = BPV_BITS_MAX'(work_i >> rsh);
    c1_o     = BPV_BITS_MAX'(after_c0 >> rsh);
    shamt_o  = use2x2_i ? {2'b00, b_i} : {1'b0, b_i, 1'b0};
  end

endmodule

// File: rtl/dec_bpv_parser.sv
// Sequential BPV parser: accepts one block's BP suffix, parses one partition
// per cycle into 2x2 or 2x1 vectors, and hands back the vectors, the bit
// count consumed and the realigned suffix.
module dec_bpv_parser
  import dec_bp_pkg::*;
#(
  parameter int SUFFIX_W   = 128,
  parameter int NUM_PART   = 4,
  parameter int BPV_W      = 8,
  parameter int FLS_OFFSET = FLS_OFFSET_DEFAULT
) (
  input logic          clk,
  input logic          rst_n,
  dec_bpv_parser_if.slave bus
);

  localparam int IDX_W = (NUM_PART > 1) ? $clog2(NUM_PART) : 1;

  state_e                    state_q, state_d;
  logic [SUFFIX_W-1:0]       work_q;
  logic [NUM_PART-1:0]       use2x2_q;
  logic [2:0]                b_q;
  logic                      fls_q;
  logic [IDX_W-1:0]          idx_q;
  logic [7:0]                ptr_q;
  logic [NUM_PART*BPV_W-1:0] p0_q, p1_q;

  logic                      accept;
  logic                      last_part;
  logic                      done;
  logic                      ovr;
  logic [BPV_BITS_MAX-1:0]   c0, c1;
  logic [4:0]                shamt;
  logic [BPV_W-1:0]          off, v0, v1;

  assign accept    = bus.in_valid && (state_q == ST_IDLE);
  assign last_part = (idx_q == IDX_W'(NUM_PART - 1));
  assign done      = (state_q == ST_DONE);
  // ptr may run past the end of the suffix when the stream is truncated.
  assign ovr       = (int'(ptr_q) > SUFFIX_W);

  dec_bpv_extract #(
    .SUFFIX_W (SUFFIX_W)
  ) u_extract (
    .work_i   (work_q),
    .b_i      (b_q),
    .use2x2_i (use2x2_q[idx_q]),
    .c0_o     (c0),
    .c1_o     (c1),
    .shamt_o  (shamt)
  );

  assign off = fls_q ? BPV_W'(FLS_OFFSET) : '0;
  assign v0  = BPV_W'(c0) + off;
  // A 2x2 partition carries a single vector, mirrored into both outputs.
  assign v1  = use2x2_q[idx_q] ? v0 : (BPV_W'(c1) + off);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: idle until a request, one cycle per partition, then hold
  // the result until the consumer takes it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.in_valid)  state_d = ST_PARSE;
      ST_PARSE: if (last_part)     state_d = ST_DONE;
      ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Block capture at accept, then per-partition vector write and consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q   <= '0;
      use2x2_q <= '0;
      b_q      <= '0;
      fls_q    <= 1'b0;
      idx_q    <= '0;
      ptr_q    <= '0;
      p0_q     <= '0;
      p1_q     <= '0;
    end else if (accept) begin
      work_q   <= bus.suffix;
      use2x2_q <= bus.use2x2;
      b_q      <= calc_b(bus.bpv_num_bits, bus.is_fls);
      fls_q    <= bus.is_fls;
      idx_q    <= '0;
      ptr_q    <= '0;
      p0_q     <= '0;
      p1_q     <= '0;
    end else if (state_q == ST_PARSE) begin
      p0_q[idx_q*BPV_W +: BPV_W] <= v0;
      p1_q[idx_q*BPV_W +: BPV_W] <= v1;
      work_q                     <= work_q << shamt;
      ptr_q                      <= ptr_q + {3'b000, shamt};
      if (!last_part) idx_q <= idx_q + IDX_W'(1);
    end
  end

  // Size, realigned suffix and overrun are only meaningful once parsing is
  // complete; they read 0 in every other state.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = done;
  assign bus.bpv_p0    = p0_q;
  assign bus.bpv_p1    = p1_q;
  assign bus.overrun   = done && ovr;
  assign bus.bpv_size  = !done ? 8'd0 : (ovr ? 8'(SUFFIX_W) : ptr_q);
  assign bus.suffix_rm = (done && !ovr) ? work_q : '0;

endmodule

// File: tb/tb_dec_bpv_parser.sv
// Bench for dec_bpv_parser: directed and randomized blocks on a 128-bit and
// a 32-bit instance, compared against a bit-position reference model.
module tb_dec_bpv_parser;

  localparam int NP  = 4;
  localparam int BW  = 8;
  localparam int OFF = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dec_bpv_parser_if #(.SUFFIX_W(128), .NUM_PART(NP), .BPV_W(BW)) bus();
  dec_bpv_parser_if #(.SUFFIX_W(32),  .NUM_PART(NP), .BPV_W(BW)) bus32();

  dec_bpv_parser #(.SUFFIX_W(128), .NUM_PART(NP), .BPV_W(BW), .FLS_OFFSET(OFF)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  dec_bpv_parser #(.SUFFIX_W(32), .NUM_PART(NP), .BPV_W(BW), .FLS_OFFSET(OFF)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus32));

  int vectors = 0;
  int miscompares = 0;

  logic [NP*BW-1:0] m_p0, m_p1;
  logic [7:0]       m_size;
  logic [127:0]     m_rm;
  logic             m_ovr;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream bit k is s[127-k] for k < sw; everything past the end reads 0.
  function automatic int rd(input logic [127:0] s, input int sw, input int pos, input int b);
    int v;
    v = 0;
    for (int j = 0; j < b; j++) begin
      v = v * 2 + (((pos + j) < sw) ? int'(s[127-(pos+j)]) : 0);
    end
    return v;
  endfunction

  task automatic model(input logic [127:0] s, input int sw, input logic [3:0] u,
                       input int nb, input bit fls);
    int b, pos, c0, c1, off;
    b = fls ? nb - 1 : nb;
    if (b < 1 || b > 7) b = 0;
    off = fls ? OFF : 0;
    pos = 0;
    m_p0 = '0;
    m_p1 = '0;
    for (int i = 0; i < NP; i++) begin
      c0 = rd(s, sw, pos, b);
      pos += b;
      if (u[i]) c1 = c0;
      else begin
        c1 = rd(s, sw, pos, b);
        pos += b;
      end
      m_p0[i*BW +: BW] = BW'(c0 + off);
      m_p1[i*BW +: BW] = BW'(c1 + off);
    end
    m_ovr  = (pos > sw);
    m_size = 8'(m_ovr ? sw : pos);
    m_rm   = '0;
    for (int k = 0; k < sw; k++) m_rm[127-k] = ((k + pos) < sw) ? s[127-(k+pos)] : 1'b0;
  endtask

  function automatic logic          g_rdy(input bit s32);  return s32 ? bus32.in_ready  : bus.in_ready;  endfunction
  function automatic logic          g_ov(input bit s32);   return s32 ? bus32.out_valid : bus.out_valid; endfunction
  function automatic logic [31:0]   g_p0(input bit s32);   return s32 ? bus32.bpv_p0    : bus.bpv_p0;    endfunction
  function automatic logic [31:0]   g_p1(input bit s32);   return s32 ? bus32.bpv_p1    : bus.bpv_p1;    endfunction
  function automatic logic [7:0]    g_size(input bit s32); return s32 ? bus32.bpv_size  : bus.bpv_size;  endfunction
  function automatic logic          g_ovr(input bit s32);  return s32 ? bus32.overrun   : bus.overrun;   endfunction
  function automatic logic [127:0]  g_rm(input bit s32);
    return s32 ? {bus32.suffix_rm, 96'b0} : bus.suffix_rm;
  endfunction

  task automatic drive_req(input bit s32, input bit v, input logic [127:0] s,
                           input logic [3:0] u, input logic [3:0] nb, input bit fls);
    if (s32) begin
      bus32.in_valid = v; bus32.suffix = s[127:96]; bus32.use2x2 = u;
      bus32.bpv_num_bits = nb; bus32.is_fls = fls;
    end else begin
      bus.in_valid = v; bus.suffix = s; bus.use2x2 = u;
      bus.bpv_num_bits = nb; bus.is_fls = fls;
    end
  endtask

  task automatic set_ordy(input bit s32, input bit r);
    if (s32) bus32.out_ready = r;
    else     bus.out_ready = r;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full block: accept, latency, results, optional stall, handoff.
  task automatic do_block(input bit s32, input logic [127:0] s, input logic [3:0] u,
                          input logic [3:0] nb, input bit fls, input int stall);
    int n;
    model(s, s32 ? 32 : 128, u, int'(nb), fls);
    @(negedge clk);
    n = 0;
    while (!g_rdy(s32) && n < 20) begin @(negedge clk); n++; end
    chk("in_ready_before_accept", g_rdy(s32), 1);
    drive_req(s32, 1'b1, s, u, nb, fls);
    @(posedge clk);
    @(negedge clk);
    drive_req(s32, 1'b0, rnd128(), 4'($urandom), 4'($urandom), 1'($urandom));
    chk("p0_cleared_at_accept", g_p0(s32), 0);
    chk("in_ready_parse", g_rdy(s32), 0);
    n = 1;
    while (!g_ov(s32) && n < 20) begin @(negedge clk); n++; end
    chk("latency", n, NP + 1);
    chk("bpv_p0", g_p0(s32), m_p0);
    chk("bpv_p1", g_p1(s32), m_p1);
    chk("bpv_size", g_size(s32), m_size);
    chk("suffix_rm", g_rm(s32), m_rm);
    chk("overrun", g_ovr(s32), m_ovr);
    for (int k = 0; k < stall; k++) begin
      drive_req(s32, 1'b1, rnd128(), 4'($urandom), 4'($urandom), 1'($urandom));
      @(negedge clk);
      chk("stall_out_valid", g_ov(s32), 1);
      chk("stall_in_ready", g_rdy(s32), 0);
      chk("stall_p0", g_p0(s32), m_p0);
      chk("stall_size", g_size(s32), m_size);
      chk("stall_rm", g_rm(s32), m_rm);
    end
    drive_req(s32, 1'b0, rnd128(), 4'($urandom), 4'($urandom), 1'($urandom));
    set_ordy(s32, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ordy(s32, 1'b0);
    chk("handoff_out_valid", g_ov(s32), 0);
    chk("handoff_in_ready", g_rdy(s32), 1);
  endtask

  initial begin
    logic [127:0] s;
    logic [31:0]  hi;
    drive_req(1'b0, 1'b0, '0, '0, '0, 1'b0);
    drive_req(1'b1, 1'b0, '0, '0, '0, 1'b0);
    set_ordy(1'b0, 1'b0);
    set_ordy(1'b1, 1'b0);

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_p0", bus.bpv_p0, 0);
    chk("rst_p1", bus.bpv_p1, 0);
    chk("rst_size", bus.bpv_size, 0);
    chk("rst_rm", bus.suffix_rm, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst32_in_ready", bus32.in_ready, 1);
    rst_n = 1'b1;

    // FLS, all 2x2, b=5.
    s = rnd128();
    s[127:108] = 20'b10101_00011_11111_00000;
    do_block(1'b0, s, 4'b1111, 4'd6, 1'b1, 0);
    chk("fls_p0_literal", m_p0, {8'd32, 8'd63, 8'd35, 8'd53});
    chk("fls_size_literal", m_size, 20);

    // All 2x1, b=4, nibbles 1..8.
    s = rnd128();
    s[127:96] = 32'h12345678;
    do_block(1'b0, s, 4'b0000, 4'd4, 1'b0, 0);
    chk("nib_p0_literal", m_p0, {8'd7, 8'd5, 8'd3, 8'd1});
    chk("nib_p1_literal", m_p1, {8'd8, 8'd6, 8'd4, 8'd2});

    // Mixed modes, b=7, with backpressure.
    do_block(1'b0, rnd128(), 4'b0101, 4'd7, 1'b0, 10);
    chk("mixed_size_literal", m_size, 42);

    // Out-of-range width: b collapses to 0, offset still applied in FLS.
    do_block(1'b0, rnd128(), 4'b0000, 4'd8, 1'b0, 0);
    do_block(1'b0, rnd128(), 4'b0011, 4'd1, 1'b1, 0);
    chk("b0_fls_p0_literal", m_p0, {4{8'd32}});

    // Truncated 32-bit suffix: b=7, all 2x1, 56 bits requested.
    s = rnd128();
    do_block(1'b1, s, 4'b0000, 4'd8, 1'b1, 0);
    chk("ovr_size_literal", m_size, 32);
    chk("ovr_flag_literal", m_ovr, 1);
    do_block(1'b1, rnd128(), 4'b1111, 4'd7, 1'b0, 2);

    // Reset during PARSE with idx=2.
    s = rnd128();
    model(s, 128, 4'b0000, 5, 1'b0);
    @(negedge clk);
    drive_req(1'b0, 1'b1, s, 4'b0000, 4'd5, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive_req(1'b0, 1'b0, rnd128(), 4'b0, 4'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    hi = bus.bpv_p0;
    chk("unparsed_p0_zero", hi[31:16], 0);
    chk("parsed_p0_part0", hi[7:0], m_p0[7:0]);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_p0", bus.bpv_p0, 0);
    chk("mid_rst_p1", bus.bpv_p1, 0);
    chk("mid_rst_size", bus.bpv_size, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_block(1'b0, rnd128(), 4'b1010, 4'd6, 1'b0, 0);

    // Randomized blocks on both instances.
    for (int r = 0; r < 10; r++) begin
      do_block(1'b0, rnd128(), 4'($urandom), 4'($urandom_range(2, 8)), 1'($urandom),
               int'($urandom_range(0, 3)));
    end
    for (int r = 0; r < 4; r++) begin
      do_block(1'b1, rnd128(), 4'($urandom), 4'($urandom_range(2, 8)), 1'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
